debug_wb_master: RTL and testbench

- Wishbone classic single-transfer initiator.
- Turns a valid/ready command stream (from a testbench-driven housekeeping port or the management SoC side) into one WB read or write.
- Returns the read data or a write completion on a valid/ready response stream.
- Primary target is the debug-register responder at offsets 0x8/0xC; works with any single-cycle-ack WB slave.
- A bounded ack timeout guarantees the response stream never hangs.

---
 rtl/debug_wb_pkg.sv | 8 +
 rtl/debug_wb_master_tmo_counter.sv | 20 ++
 rtl/debug_wb_master.sv | 113 +++++++++++
 tb/tb_debug_wb_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_wb_pkg.sv
// debug_wb_pkg: shared state encoding and constants for the debug Wishbone initiator
package debug_wb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
    localparam logic [3:0] DBG_REG1_OFS = 4'h8;
    localparam logic [3:0] DBG_REG2_OFS = 4'hC;
    localparam int DEFAULT_TIMEOUT = 255;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hBADD_BADD;
endpackage

// File: rtl/debug_wb_master_tmo_counter.sv
// wb_tmo_counter: counts unacknowledged strobe cycles; expired marks the last allowed one
module wb_tmo_counter
    import debug_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/debug_wb_master.sv
// debug_wb_master: single-transfer WB classic initiator with ack timeout.
// Optional transfer statistics under DEBUG_WB_MASTER_STATS_EN.
module debug_wb_master
    import debug_wb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [15:0] stat_txn_cnt,
    output logic [15:0] stat_tmo_cnt
);
    state_t state, state_nx;
    logic acc, ack_done, tmo, expired;

    // cmd_ready is gated by reset so it reads 0 while reset is held
    assign cmd_ready = (state == IDLE) && !wb_rst_i;
    assign acc       = cmd_ready && cmd_valid;
    assign ack_done  = (state == BUS) && wbm_ack_i;
    assign tmo       = (state == BUS) && !wbm_ack_i && expired;

    wb_tmo_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .clr     (acc),
        .inc     ((state == BUS) && !wbm_ack_i),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = acc ? BUS :
                   (ack_done || tmo) ? RESP :
                   ((state == RESP) && rsp_ready) ? IDLE : state;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (acc) begin
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
            end
            if (ack_done) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                wbm_we_o  <= 1'b0;
                rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
            end else if (tmo) begin
                wbm_cyc_o <= 1'b0;
                wbm_stb_o <= 1'b0;
                rsp_dat   <= wbm_we_o ? '0 : ERR_DATA;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_dat   <= '0;
                rsp_err   <= 1'b0;
            end
        end

`ifdef DEBUG_WB_MASTER_STATS_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            stat_txn_cnt <= '0;
            stat_tmo_cnt <= '0;
        end else begin
            if (ack_done) stat_txn_cnt <= stat_txn_cnt + 1'b1;
            if (tmo) stat_tmo_cnt <= stat_tmo_cnt + 1'b1;
        end
`else
    assign stat_txn_cnt = '0;
    assign stat_tmo_cnt = '0;
`endif
endmodule

// File: tb/tb_debug_wb_master.sv
// tb_debug_wb_master: randomized checks of the WB initiator against a debug-register responder
module tb_debug_wb_master;
    import debug_wb_pkg::*;
    localparam int TMO = 8;
`ifdef DEBUG_WB_MASTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [3:0] cmd_sel = '0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic cmd_ready, rsp_valid, rsp_err, cyc, stb, we, ack;
    logic [3:0] sel;
    logic [31:0] rsp_dat, adr, dat_o, dat_i;
    logic [15:0] stat_txn, stat_tmo;

    int vec = 0, err = 0;
    int lat, stb_n, m_txn = 0, m_tmo = 0;
    logic saw_we, got_err;
    logic [31:0] got_dat, cap_adr, cap_dat;
    logic [3:0] cap_sel;
    logic [31:0] m_reg [2];
    logic [31:0] s_r8, s_rc;

    always #5 clk = ~clk;

    debug_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
        .stat_txn_cnt(stat_txn), .stat_tmo_cnt(stat_tmo)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // debug-register responder: registered ack, only offsets 0x8 and 0xC answer
    always @(posedge clk or posedge rst)
        if (rst) begin
            ack <= 1'b0; dat_i <= '0; s_r8 <= '0; s_rc <= '0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && (adr == {28'h0, DBG_REG1_OFS} || adr == {28'h0, DBG_REG2_OFS})) begin
                ack <= 1'b1;
                dat_i <= (adr == 32'h8) ? s_r8 : s_rc;
                if (we && adr == 32'h8) s_r8 <= merge(s_r8, dat_o, sel);
                if (we && adr == 32'hC) s_rc <= merge(s_rc, dat_o, sel);
            end
        end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_txn(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d, input int hold);
        int g = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = w; cmd_sel = s; cmd_adr = a; cmd_dat = d;
        while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1; stb_n = 0; saw_we = 1'b0;
        while (!rsp_valid && lat < 50) begin
            if (stb) begin
                if (stb_n == 0) begin cap_adr = adr; cap_sel = sel; cap_dat = dat_o; end
                stb_n++;
                saw_we |= we;
            end
            @(negedge clk);
            lat++;
        end
        got_dat = rsp_dat; got_err = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // reference: offsets 0x8/0xC are byte-enabled registers, everything else times out
    task automatic model(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] e_dat, output logic e_err, output int e_lat, output int e_stb);
        if (a == 32'h8 || a == 32'hC) begin
            e_dat = w ? 32'h0 : m_reg[a == 32'hC];
            if (w) m_reg[a == 32'hC] = merge(m_reg[a == 32'hC], d, s);
            e_err = 1'b0; e_lat = 3; e_stb = 2; m_txn++;
        end else begin
            e_dat = w ? 32'h0 : 32'hBADD_BADD;
            e_err = 1'b1; e_lat = TMO + 1; e_stb = TMO; m_tmo++;
        end
    endtask

    task automatic txn_check(input string nm, input logic w, input logic [3:0] s, input logic [31:0] a,
                             input logic [31:0] d, input int hold);
        logic [31:0] e_dat;
        logic e_err;
        int e_lat, e_stb;
        model(w, s, a, d, e_dat, e_err, e_lat, e_stb);
        do_txn(w, s, a, d, hold);
        vec++;
        if ({got_err, got_dat} !== {e_err, e_dat}) begin
            err++;
            $display("FAIL %s rsp: got err=%0b dat=%h expected err=%0b dat=%h", nm, got_err, got_dat, e_err, e_dat);
        end
        vec++;
        if (lat !== e_lat || stb_n !== e_stb) begin
            err++;
            $display("FAIL %s timing: got lat=%0d stb=%0d expected lat=%0d stb=%0d", nm, lat, stb_n, e_lat, e_stb);
        end
        vec++;
        if ({cap_adr, cap_sel, saw_we} !== {a, s, w} || (w && cap_dat !== d)) begin
            err++;
            $display("FAIL %s bus: got adr=%h sel=%h we=%0b dat=%h expected adr=%h sel=%h we=%0b dat=%h",
                     nm, cap_adr, cap_sel, saw_we, cap_dat, a, s, w, d);
        end
        vec++;
        if ({stat_txn, stat_tmo} !== (STATS ? {16'(m_txn), 16'(m_tmo)} : 32'h0)) begin
            err++;
            $display("FAIL %s stats: got txn=%0d tmo=%0d expected txn=%0d tmo=%0d", nm, stat_txn, stat_tmo,
                     STATS ? m_txn : 0, STATS ? m_tmo : 0);
        end
    endtask

    task automatic test_reset;
        m_reg[0] = '0; m_reg[1] = '0;
        repeat (2) @(negedge clk);
        vec++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_dat, cyc, stb, we, sel, adr, dat_o, stat_txn, stat_tmo} !== '0) begin
            err++;
            $display("FAIL reset outputs: got rdy=%0b rv=%0b cyc=%0b stb=%0b rsp=%h expected all zero",
                     cmd_ready, rsp_valid, cyc, stb, rsp_dat);
        end
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if (cmd_ready !== 1'b1) begin err++; $display("FAIL reset idle ready: got %0b expected 1", cmd_ready); end
    endtask

    task automatic test_write_read;
        txn_check("write_0xC", 1'b1, 4'hF, 32'hC, 32'h1234_5678, 0);
        txn_check("read_0xC", 1'b0, 4'hF, 32'hC, 32'h0, 1);
        vec++;
        if (got_dat !== 32'h1234_5678) begin err++; $display("FAIL readback: got %h expected 12345678", got_dat); end
    endtask

    task automatic test_byte_enable;
        txn_check("be_write", 1'b1, 4'b0010, 32'h8, 32'hAABB_CCDD, 0);
        txn_check("be_read", 1'b0, 4'hF, 32'h8, 32'h0, 0);
        vec++;
        if (got_dat !== 32'h0000_CC00) begin err++; $display("FAIL be readback: got %h expected 0000cc00", got_dat); end
        txn_check("sel0_write", 1'b1, 4'b0000, 32'h8, 32'hFFFF_FFFF, 0);
        txn_check("sel0_read", 1'b0, 4'hF, 32'h8, 32'h0, 0);
    endtask

    task automatic test_timeout;
        txn_check("tmo_read", 1'b0, 4'hF, 32'h4, 32'h0, 0);
        vec++;
        if ({got_err, got_dat, stb_n} !== {1'b1, 32'hBADD_BADD, 32'(TMO)}) begin
            err++;
            $display("FAIL tmo read: got err=%0b dat=%h stb=%0d expected 1 baddbadd %0d", got_err, got_dat, stb_n, TMO);
        end
        txn_check("tmo_write", 1'b1, 4'hF, 32'h4, 32'h5555_AAAA, 2);
    endtask

    task automatic test_backpressure;
        logic [31:0] e_dat;
        logic e_err;
        int e_lat, e_stb, g;
        model(1'b0, 4'hF, 32'hC, 32'h0, e_dat, e_err, e_lat, e_stb);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'hC;
        @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 32'h8; cmd_dat = 32'h0BAD_F00D;
        g = 0;
        while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
        for (int i = 0; i < 10; i++) begin
            vec++;
            if ({rsp_valid, rsp_dat, rsp_err, cmd_ready, stb} !== {1'b1, e_dat, 1'b0, 1'b0, 1'b0}) begin
                err++;
                $display("FAIL hold[%0d]: got rv=%0b dat=%h rdy=%0b stb=%0b expected rv=1 dat=%h rdy=0 stb=0",
                         i, rsp_valid, rsp_dat, cmd_ready, stb, e_dat);
            end
            @(negedge clk);
        end
        model(1'b1, 4'hF, 32'h8, 32'h0BAD_F00D, e_dat, e_err, e_lat, e_stb);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vec++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            err++;
            $display("FAIL release: got rv=%0b rdy=%0b expected rv=0 rdy=1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vec++;
        if ({stb, we, adr} !== {1'b1, 1'b1, 32'h8}) begin
            err++;
            $display("FAIL queued accept: got stb=%0b we=%0b adr=%h expected 1 1 00000008", stb, we, adr);
        end
        g = 0;
        while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
        vec++;
        if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
            err++;
            $display("FAIL queued rsp: got rv=%0b err=%0b dat=%h expected 1 0 0", rsp_valid, rsp_err, rsp_dat);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h8;
                1: a = 32'hC;
                2: a = 32'h4;
                3: a = 32'h10;
                default: a = 32'hD;
            endcase
            txn_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                      int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'hC;
        @(negedge clk);
        cmd_valid = 1'b0;
        vec++;
        if (stb !== 1'b1) begin err++; $display("FAIL pre-reset stb: got %0b expected 1", stb); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0) begin
            err++;
            $display("FAIL async reset: got cyc=%0b stb=%0b rv=%0b rdy=%0b expected all 0", cyc, stb, rsp_valid, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reg[0] = '0; m_reg[1] = '0; m_txn = 0; m_tmo = 0;
        txn_check("post_reset_read", 1'b0, 4'hF, 32'hC, 32'h0, 0);
        vec++;
        if (got_dat !== 32'h0) begin err++; $display("FAIL post-reset data: got %h expected 0", got_dat); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_timeout();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
